// File: rtl/sobel_frame_ctrl.sv
// Sobel frame sequencer: two line buffers and a 3x3 window feed the magnitude unit,
// and a latency-matched tag pipeline re-attaches centre coordinates to its results.
module sobel_frame_ctrl #(
  parameter int unsigned IMG_W   = 128,
  parameter int unsigned IMG_H   = 128,
  parameter int unsigned MAG_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [7:0]                 in_pixel,
  output logic                       in_ready,
  output logic [7:0]                 p0,
  output logic [7:0]                 p1,
  output logic [7:0]                 p2,
  output logic [7:0]                 p3,
  output logic [7:0]                 p5,
  output logic [7:0]                 p6,
  output logic [7:0]                 p7,
  output logic [7:0]                 p8,
  output logic                       win_valid,
  input  logic [7:0]                 mag_in,
  output logic                       out_valid,
  output logic [7:0]                 out_pixel,
  output logic [$clog2(IMG_W)-1:0]   out_x,
  output logic [$clog2(IMG_H)-1:0]   out_y,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned TL = MAG_LAT - 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    c4;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          tag_v [MAG_LAT];
  logic [XW-1:0] tag_x [MAG_LAT];
  logic [YW-1:0] tag_y [MAG_LAT];

  logic accept_c;
  logic frame_end_c;
  logic tag_any_c;

  assign accept_c    = in_valid && in_ready;
  assign frame_end_c = accept_c && (x == X_LAST) && (y == Y_LAST);

  always_comb begin
    tag_any_c = 1'b0;
    for (int i = 0; i < int'(MAG_LAT); i++) tag_any_c = tag_any_c | tag_v[i];
  end

  // Frame sequencer with raster counters; in_ready/busy/done track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            x        <= '0;
            y        <= '0;
          end
        end
        RUN: begin
          if (accept_c) begin
            if (x == X_LAST) begin
              x <= '0;
              y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
            if (frame_end_c) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // Last result has been emitted once nothing is left in flight.
          if (!win_valid && !tag_any_c) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Line buffers carry no reset; stale rows are masked by the win_valid row gate.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lb1[x] <= lb0[x];
      lb0[x] <= in_pixel;
    end
  end

  // Window shift, tag pipeline and output re-alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {p0, p1, p2, p3, c4, p5, p6, p7, p8} <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      for (int i = 0; i < int'(MAG_LAT); i++) begin
        tag_v[i] <= 1'b0;
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      win_valid <= 1'b0;
      if (accept_c) begin
        p0 <= p1;  p1 <= p2;  p2 <= lb1[x];
        p3 <= c4;  c4 <= p5;  p5 <= lb0[x];
        p6 <= p7;  p7 <= p8;  p8 <= in_pixel;
        win_valid <= (x >= XW'(2)) && (y >= YW'(2));
        win_x     <= x - XW'(1);
        win_y     <= y - YW'(1);
      end
      tag_v[0] <= win_valid;
      tag_x[0] <= win_x;
      tag_y[0] <= win_y;
      for (int i = 1; i < int'(MAG_LAT); i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_x[i] <= tag_x[i-1];
        tag_y[i] <= tag_y[i-1];
      end
      out_valid <= tag_v[TL];
      if (tag_v[TL]) begin
        out_pixel <= mag_in;
        out_x     <= tag_x[TL];
        out_y     <= tag_y[TL];
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: a 5x4 instance and a minimal 3x3 instance, each with a
// behavioural Sobel unit on mag_in, compared against outputs computed from the source image.
module tb_sobel_frame_ctrl;

  localparam int W_A = 5, H_A = 4, LAT_A = 2;
  localparam int W_B = 3, H_B = 3, LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_a, in_valid_a, in_ready_a, win_valid_a, out_valid_a, busy_a, done_a;
  logic [7:0] in_pixel_a, mag_a, out_pixel_a;
  logic [7:0] pa0, pa1, pa2, pa3, pa5, pa6, pa7, pa8;
  logic [2:0] out_x_a;
  logic [1:0] out_y_a;

  logic       start_b, in_valid_b, in_ready_b, win_valid_b, out_valid_b, busy_b, done_b;
  logic [7:0] in_pixel_b, mag_b, out_pixel_b;
  logic [7:0] pb0, pb1, pb2, pb3, pb5, pb6, pb7, pb8;
  logic [1:0] out_x_b;
  logic [1:0] out_y_b;

  sobel_frame_ctrl #(.IMG_W(W_A), .IMG_H(H_A), .MAG_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid_a), .in_pixel(in_pixel_a),
    .in_ready(in_ready_a), .p0(pa0), .p1(pa1), .p2(pa2), .p3(pa3), .p5(pa5), .p6(pa6),
    .p7(pa7), .p8(pa8), .win_valid(win_valid_a), .mag_in(mag_a), .out_valid(out_valid_a),
    .out_pixel(out_pixel_a), .out_x(out_x_a), .out_y(out_y_a), .busy(busy_a), .done(done_a));

  sobel_frame_ctrl #(.IMG_W(W_B), .IMG_H(H_B), .MAG_LAT(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b), .in_pixel(in_pixel_b),
    .in_ready(in_ready_b), .p0(pb0), .p1(pb1), .p2(pb2), .p3(pb3), .p5(pb5), .p6(pb6),
    .p7(pb7), .p8(pb8), .win_valid(win_valid_b), .mag_in(mag_b), .out_valid(out_valid_b),
    .out_pixel(out_pixel_b), .out_x(out_x_b), .out_y(out_y_b), .busy(busy_b), .done(done_b));

  // Sobel magnitude: (|Gx| + |Gy|) bits [9:2].
  function automatic logic [7:0] sobel8(input int a0, a1, a2, a3, a5, a6, a7, a8);
    int gx, gy;
    logic [31:0] s;
    gx = (a2 + 2*a5 + a8) - (a0 + 2*a3 + a6);
    gy = (a6 + 2*a7 + a8) - (a0 + 2*a1 + a2);
    s  = 32'((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy));
    return s[9:2];
  endfunction

  // Behavioural magnitude units with fixed latency.
  logic [7:0] mpa [LAT_A];
  logic [7:0] mpb [LAT_B];
  always @(posedge clk) begin
    mpa[0] <= sobel8(pa0, pa1, pa2, pa3, pa5, pa6, pa7, pa8);
    for (int i = 1; i < LAT_A; i++) mpa[i] <= mpa[i-1];
    mpb[0] <= sobel8(pb0, pb1, pb2, pb3, pb5, pb6, pb7, pb8);
    for (int i = 1; i < LAT_B; i++) mpb[i] <= mpb[i-1];
  end
  assign mag_a = mpa[LAT_A-1];
  assign mag_b = mpb[LAT_B-1];

  typedef struct { logic [31:0] x, y, v, c; } ev_t;
  ev_t cap_a[$], cap_b[$];
  int  done_a_q[$], done_b_q[$];
  int  wv_a = 0;

  always @(negedge clk) begin
    ev_t e;
    if (out_valid_a === 1'b1) begin
      e.x = 32'(out_x_a); e.y = 32'(out_y_a); e.v = 32'(out_pixel_a); e.c = 32'(cyc);
      cap_a.push_back(e);
    end
    if (out_valid_b === 1'b1) begin
      e.x = 32'(out_x_b); e.y = 32'(out_y_b); e.v = 32'(out_pixel_b); e.c = 32'(cyc);
      cap_b.push_back(e);
    end
    if (done_a === 1'b1) done_a_q.push_back(cyc);
    if (done_b === 1'b1) done_b_q.push_back(cyc);
    if (win_valid_a === 1'b1) wv_a++;
  end

  int checks = 0;
  int errors = 0;
  int img_a [W_A*H_A];
  int acc_a [W_A*H_A];
  int img_b [W_B*H_B];
  int acc_b [W_B*H_B];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pix_a(input int px, input int py);
    return img_a[py*W_A + px];
  endfunction

  task automatic check_reset_a(input string tag);
    chk({tag, ".ctl"}, 32'({busy_a, done_a, in_ready_a, win_valid_a, out_valid_a}), 32'(0));
    chk({tag, ".out"}, 32'({out_pixel_a, out_x_a, out_y_a}), 32'(0));
    chk({tag, ".winl"}, {pa0, pa1, pa2, pa3}, 32'(0));
    chk({tag, ".winh"}, {pa5, pa6, pa7, pa8}, 32'(0));
  endtask

  // gap_mode: 0 none, 1 alternate idle cycle, 2 random idle cycles.
  task automatic drive_frame_a(input int gap_mode, input int start_run_idx, input bit start_flush,
                               input int stop_idx);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int i = 0; i < W_A*H_A; i++) begin
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid_a = 1'b0;
        @(posedge clk); #1;
      end
      in_valid_a = 1'b1;
      in_pixel_a = 8'(img_a[i]);
      start_a    = (i == start_run_idx);
      chk("in_ready", 32'(in_ready_a), 32'(1));
      acc_a[i] = cyc;
      @(posedge clk); #1;
      start_a = 1'b0;
      if (i == stop_idx) begin
        in_valid_a = 1'b0;
        return;
      end
    end
    in_valid_a = 1'b0;
    if (start_flush) begin
      start_a = 1'b1;
      chk("flush_state", 32'({busy_a, in_ready_a}), 32'(2));
      @(posedge clk); #1 start_a = 1'b0;
    end
  endtask

  task automatic check_frame_a(input string tag);
    ev_t exp[$];
    ev_t e;
    int n;
    for (int cy = 1; cy <= H_A-2; cy++)
      for (int cx = 1; cx <= W_A-2; cx++) begin
        e.x = 32'(cx); e.y = 32'(cy);
        e.v = 32'(sobel8(pix_a(cx-1, cy-1), pix_a(cx, cy-1), pix_a(cx+1, cy-1), pix_a(cx-1, cy),
                         pix_a(cx+1, cy), pix_a(cx-1, cy+1), pix_a(cx, cy+1), pix_a(cx+1, cy+1)));
        e.c = 32'(acc_a[(cy+1)*W_A + cx + 1] + 2 + LAT_A);
        exp.push_back(e);
      end
    n = 0;
    while (done_a_q.size() == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, ".count"}, 32'(cap_a.size()), 32'(exp.size()));
    chk({tag, ".wv_count"}, 32'(wv_a), 32'(exp.size()));
    for (int i = 0; i < cap_a.size() && i < exp.size(); i++) begin
      chk($sformatf("%s.x%0d", tag, i), cap_a[i].x, exp[i].x);
      chk($sformatf("%s.y%0d", tag, i), cap_a[i].y, exp[i].y);
      chk($sformatf("%s.pix%0d", tag, i), cap_a[i].v, exp[i].v);
      chk($sformatf("%s.cyc%0d", tag, i), cap_a[i].c, exp[i].c);
    end
    chk({tag, ".done_count"}, 32'(done_a_q.size()), 32'(1));
    chk({tag, ".done_cyc"}, 32'(done_a_q.size() > 0 ? done_a_q[0] : -1), exp[exp.size()-1].c + 1);
    chk({tag, ".idle"}, 32'({busy_a, in_ready_a}), 32'(0));
    cap_a.delete();
    done_a_q.delete();
    wv_a = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; in_valid_a = 1'b0; in_pixel_a = 8'h00;
    start_b = 1'b0; in_valid_b = 1'b0; in_pixel_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("reset");
    chk("reset_b", 32'({busy_b, done_b, in_ready_b, win_valid_b, out_valid_b}), 32'(0));
    rst_n = 1'b1;

    // Constant image: zero magnitude everywhere.
    for (int i = 0; i < W_A*H_A; i++) img_a[i] = 8'h80;
    drive_frame_a(0, -1, 1'b0, -1);
    check_frame_a("const");

    // Horizontal ramp, gap-free then with alternating idle cycles.
    for (int i = 0; i < W_A*H_A; i++) img_a[i] = 10 * (i % W_A);
    drive_frame_a(0, -1, 1'b0, -1);
    check_frame_a("ramp");
    drive_frame_a(1, -1, 1'b0, -1);
    check_frame_a("ramp_gap");

    // Random image with stray start pulses in RUN and FLUSH.
    for (int i = 0; i < W_A*H_A; i++) img_a[i] = int'($urandom_range(0, 255));
    drive_frame_a(0, 7, 1'b1, -1);
    check_frame_a("start_ignored");

    // Reset right after pixel (2,2) is accepted, then a fresh frame.
    for (int i = 0; i < W_A*H_A; i++) img_a[i] = int'($urandom_range(0, 255));
    drive_frame_a(0, -1, 1'b0, 2*W_A + 2);
    chk("pre_reset_wv", 32'(win_valid_a), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_reset_a("mid_reset");
    cap_a.delete();
    done_a_q.delete();
    wv_a = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < W_A*H_A; i++) img_a[i] = int'($urandom_range(0, 255));
    drive_frame_a(2, -1, 1'b0, -1);
    check_frame_a("after_reset");

    // Minimal 3x3 frame: only the bottom row is bright.
    for (int i = 0; i < W_B*H_B; i++) img_b[i] = (i >= 2*W_B) ? 255 : 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int i = 0; i < W_B*H_B; i++) begin
      in_valid_b = 1'b1;
      in_pixel_b = 8'(img_b[i]);
      acc_b[i]   = cyc;
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    n = 0;
    while (done_b_q.size() == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("min.count", 32'(cap_b.size()), 32'(1));
    if (cap_b.size() > 0) begin
      chk("min.x", cap_b[0].x, 32'(1));
      chk("min.y", cap_b[0].y, 32'(1));
      chk("min.pix", cap_b[0].v, 32'(255));
      chk("min.cyc", cap_b[0].c, 32'(acc_b[W_B*H_B-1] + 2 + LAT_B));
    end
    chk("min.done_count", 32'(done_b_q.size()), 32'(1));
    chk("min.done_cyc", 32'(done_b_q.size() > 0 ? done_b_q[0] : -1),
        32'(acc_b[W_B*H_B-1] + 3 + LAT_B));
    chk("min.idle", 32'(busy_b), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer for the Sobel edge-detection path. It accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 window register. It presents the eight neighbour pixels of each interior pixel to the downstream `sobelmag` magnitude unit. It then re-aligns the unit's result with the pixel's coordinates, emits the edge image, and signals frame completion.

## Interface
- `IMG_W`, 128: image width in pixels; must be at least 3.
- `IMG_H`, 128: image height in lines; must be at least 3.
- `MAG_LAT`, 2: cycles from a valid window on `p*` to the matching result on `mag_in`; must be at least 1.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
- `in_valid`  in  1  `in_pixel` is valid.
- `in_pixel`  in  8  source pixel, raster order.
- `in_ready`  out  1  block accepts a pixel this cycle.
- `p0,p1,p2,p3,p5,p6,p7,p8`  out  8 each  3x3 neighbours (p0 top-left, row-major; centre p4 not driven), to the magnitude unit.
- `win_valid`  out  1  `p*` hold a valid interior window this cycle.
- `mag_in`  in  8  magnitude result from the unit.
- `out_valid`  out  1  `out_pixel` valid; the sink is always ready and there is no backpressure.
- `out_pixel`  out  8  edge magnitude.
- `out_x`, `out_y`  out  $clog2(IMG_W), $clog2(IMG_H)  centre coordinate of `out_pixel`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of frame.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE goes to RUN on `start`; the column counter `x` and row counter `y` clear to 0.
  - RUN goes to FLUSH on acceptance of pixel (`IMG_W`-1, `IMG_H`-1).
  - FLUSH goes to DONE once the valid tag pipeline is empty, i.e. after the last `out_valid`.
  - DONE goes to IDLE unconditionally after one cycle.
- `in_ready` = (state == RUN). A pixel is accepted when `in_valid && in_ready`. Cycles without acceptance change nothing: no shift, no counter step, `win_valid` = 0.
- On accepting pixel (x, y):
  - Line buffers: lb1[x] <= lb0[x] and lb0[x] <= in_pixel, so lb0 holds row y-1 and lb1 holds row y-2.
  - Window: the left column takes the middle column and the middle column takes the right column. The new right column is {lb1[x], lb0[x], in_pixel}, top to bottom.
  - Counters: x increments and wraps to 0 at `IMG_W`-1, with y then incrementing.
  - `win_valid` <= (x >= 2 && y >= 2). The window centre is (x-1, y-1).
- Only interior pixels are produced: (`IMG_W`-2)*(`IMG_H`-2) outputs per frame, in raster order. There is no border output.
- Windows straddling a row wrap (x < 2) are never flagged valid. Line-buffer contents are never cleared, and rows y < 2 are gated by `win_valid`.
- Tag pipeline: a shift register of depth `MAG_LAT` carries {`win_valid`, centre x, centre y}. When the last stage is valid, `out_pixel` <= `mag_in`, `out_x`/`out_y` <= the tag coordinates, and `out_valid` <= 1; otherwise `out_valid` <= 0.
- A `start` in any state other than IDLE is ignored.

## Timing
- Reset (asynchronous, any state, including mid-frame): state goes to IDLE, and x, y and the tag pipeline clear.
  - All outputs go to 0: `in_ready`, `win_valid`, `out_valid`, `out_pixel`, `out_x`, `out_y`, `busy`, `done`, and all `p*`.
  - Line buffers are not reset. The next frame restarts at (0,0) with no stale outputs.
- `start` sampled in cycle t gives `busy` and `in_ready` high in cycle t+1.
- A pixel accepted in cycle a gives `win_valid` in cycle a+1. `mag_in` is sampled in cycle a+1+`MAG_LAT`. `out_valid` is high in cycle a+2+`MAG_LAT`.
- Input throughput is 1 pixel/cycle. Output throughput follows input; gaps in `in_valid` propagate as gaps in `out_valid`.
- `done` is high in the cycle after the final `out_valid`. `busy` falls, and `start` is accepted again, in the following cycle.

## Test plan
- Constant image of 0x80 (`IMG_W`=5, `IMG_H`=4), with a behavioural Sobel model (MAG_LAT=2) on `mag_in`:
  - exactly 6 outputs, all 0x00;
  - coordinates (1,1),(2,1),(3,1),(1,2),(2,2),(3,2);
  - `done` one cycle after the 6th output.
- Horizontal ramp pixel = 10*x on a 5x4 image, checked against the model using the team's bit selection [9:2]. |Gx| = 80 and Gy = 0, giving 80 >> 2, so every output = 0x14.
- Same frame with `in_valid` toggled 1-0-1-0: the window-to-output offset stays at `MAG_LAT`+1 per valid, and outputs and coordinates are identical to the gap-free run.
- `start` pulsed in RUN and in FLUSH: no restart, x/y unaffected, one `done` only.
- `rst_n` asserted mid-RUN at pixel (2,2):
  - all outputs go to 0 immediately;
  - a new `start` followed by a full frame gives exactly (W-2)(H-2) correct outputs, with no leftover `out_valid`.
- Minimal 3x3 frame, with the pixel values listed in order as 0,0,0 / 0,0,0 / 255,255,255: a single output at (1,1) equal to model(Gy = 1020) >> 2 = 0xFF.
